hazard_stall_ctrl: RTL

- Parametrised hazard and stall controller for the 5-stage MIPS pipeline.
- Detects RAW hazards against the EX and MEM stages, with register 0 excluded.
- Tracks the latency of the multi-cycle MULT/DIV unit.
- Runs a memory-handshake FSM with timeout that freezes the whole pipeline while a load/store waits for acknowledge.

---
 rtl/hazard_stall_ctrl.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/hazard_stall_ctrl.sv
// rtl/hazard_stall_ctrl.sv - RAW/MULT-DIV hazard detection and memory-wait freeze control for a 5-stage MIPS pipeline
// Optional stall/freeze statistics counters built when HAZARD_STATS_EN is defined.
module hazard_stall_ctrl #(
    parameter int REG_AW      = 5,
    parameter int MD_LATENCY  = 4,
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_rt_is_source,
    input  logic [5:0]        id_opcode,
    input  logic [5:0]        id_funct,
    input  logic [REG_AW-1:0] ex_dst_reg,
    input  logic              ex_reg_write,
    input  logic [5:0]        ex_opcode,
    input  logic [REG_AW-1:0] mem_dst_reg,
    input  logic              mem_reg_write,
    input  logic [5:0]        mem_opcode,
    input  logic              mem_valid_i,
    input  logic              mem_ack_i,
    output logic              pstop_o,
    output logic              pc_write,
    output logic              if_id_write_en,
    output logic              id_ex_flush_o,
    output logic              hazard_detected_o,
    output logic              md_busy_o,
    output logic              mem_timeout_o,
    output logic [CNT_W-1:0]  stall_cycles_o,
    output logic [CNT_W-1:0]  freeze_cycles_o
);
    localparam logic [5:0] OP_LW = 6'b100011, OP_SW = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100, OP_BNE = 6'b000101, OP_SPECIAL = 6'b000000;
    localparam logic [5:0] FN_MULT = 6'b011000, FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_DIV = 6'b011010, FN_DIVU = 6'b011011;
    localparam logic [5:0] FN_MFHI = 6'b010000, FN_MFLO = 6'b010010;
    localparam int MD_W = $clog2(MD_LATENCY + 1);
    localparam int WC_W = $clog2(MEM_TIMEOUT);
    localparam logic [WC_W-1:0] WC_MAX = WC_W'(MEM_TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_TOUT} state_t;

    state_t          state_q, state_d;
    logic [WC_W-1:0] wcnt_q, wcnt_d;
    logic [MD_W-1:0] md_cnt_q, md_cnt_d;
    logic            timeout_q, timeout_d;

    logic ex_match, mem_match, id_branch, id_md, id_mf, data_haz, md_haz, acc;

    assign ex_match  = ex_reg_write && (ex_dst_reg != '0) &&
                       ((id_rs == ex_dst_reg) || (id_rt_is_source && (id_rt == ex_dst_reg)));
    assign mem_match = mem_reg_write && (mem_dst_reg != '0) &&
                       ((id_rs == mem_dst_reg) || (id_rt_is_source && (id_rt == mem_dst_reg)));
    assign id_branch = (id_opcode == OP_BEQ) || (id_opcode == OP_BNE);
    assign id_md     = (id_opcode == OP_SPECIAL) && ((id_funct == FN_MULT) || (id_funct == FN_MULTU) ||
                                                     (id_funct == FN_DIV) || (id_funct == FN_DIVU));
    assign id_mf     = (id_opcode == OP_SPECIAL) && ((id_funct == FN_MFHI) || (id_funct == FN_MFLO));

    assign data_haz  = (ex_match && ((ex_opcode == OP_LW) || id_branch)) ||
                       (mem_match && id_branch && (mem_opcode == OP_LW));
    assign md_busy_o = (md_cnt_q != '0);
    assign md_haz    = md_busy_o && (id_md || id_mf);
    assign hazard_detected_o = data_haz || md_haz;

    assign acc = mem_valid_i && ((mem_opcode == OP_LW) || (mem_opcode == OP_SW));

    always_comb begin
        state_d   = state_q;
        wcnt_d    = wcnt_q;
        timeout_d = timeout_q;
        pstop_o   = 1'b0;
        case (state_q)
            S_IDLE: begin
                // An access acknowledged in its first cycle never stalls.
                pstop_o = acc && !mem_ack_i;
                if (acc && !mem_ack_i) begin
                    state_d = S_WAIT;
                    wcnt_d  = '0;
                end
            end
            S_WAIT: begin
                pstop_o = !mem_ack_i;
                if (mem_ack_i) begin
                    state_d = S_IDLE;
                end else if (wcnt_q == WC_MAX) begin
                    state_d   = S_TOUT;
                    timeout_d = 1'b1;
                end else begin
                    wcnt_d = wcnt_q + 1'b1;
                end
            end
            S_TOUT:  state_d = S_TOUT;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        md_cnt_d = md_cnt_q;
        if (id_md && !hazard_detected_o && !pstop_o) begin
            md_cnt_d = MD_W'(MD_LATENCY);
        end else if (md_cnt_q != '0) begin
            md_cnt_d = md_cnt_q - 1'b1;
        end
    end

    // A freeze holds every stage in place, so it outranks the ID bubble.
    always_comb begin
        pc_write       = 1'b1;
        if_id_write_en = 1'b1;
        id_ex_flush_o  = 1'b0;
        if (pstop_o) begin
            pc_write       = 1'b0;
            if_id_write_en = 1'b0;
        end else if (hazard_detected_o) begin
            pc_write       = 1'b0;
            if_id_write_en = 1'b0;
            id_ex_flush_o  = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            wcnt_q    <= '0;
            md_cnt_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wcnt_q    <= wcnt_d;
            md_cnt_q  <= md_cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign mem_timeout_o = timeout_q;

`ifdef HAZARD_STATS_EN
    logic [CNT_W-1:0] stall_q, stall_d, freeze_q, freeze_d;

    always_comb begin
        stall_d  = stall_q;
        freeze_d = freeze_q;
        if (hazard_detected_o && !pstop_o && (stall_q != '1)) begin
            stall_d = stall_q + 1'b1;
        end
        if (pstop_o && (freeze_q != '1)) begin
            freeze_d = freeze_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q  <= '0;
            freeze_q <= '0;
        end else begin
            stall_q  <= stall_d;
            freeze_q <= freeze_d;
        end
    end

    assign stall_cycles_o  = stall_q;
    assign freeze_cycles_o = freeze_q;
`else
    assign stall_cycles_o  = '0;
    assign freeze_cycles_o = '0;
`endif
endmodule
